gps_stream_ctrl: RTL and testbench

Sequencing controller between the UART RX byte FIFO and the NMEA speed decoder. It pops one ASCII byte at a time from the FIFO and presents it to the decoder over a valid/ready handshake. It captures each decoded km/h result into a holding register for the display path and flags the speed as stale when no fresh result arrives within a timeout. It also keeps wrap-around byte and sentence counters for debug LEDs.

---
 rtl/gps_stream_ctrl.sv | 101 ++++++++++
 tb/tb_gps_stream_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/gps_stream_ctrl.sv
// Byte feeder from the UART RX FIFO to the NMEA speed decoder. It also holds the last
// decoded speed, raises a staleness flag on timeout and keeps debug byte/sentence counters.
module gps_stream_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 12000000,
  parameter int unsigned TIMER_W        = 24
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  input  logic [7:0]  fifo_data_i,
  input  logic        fifo_empty_i,
  output logic        fifo_rd_o,
  output logic [7:0]  dec_data_o,
  output logic        dec_valid_o,
  input  logic        dec_ready_i,
  input  logic [7:0]  dec_speed_i,
  input  logic        dec_speed_valid_i,
  output logic        dec_speed_ready_o,
  output logic [7:0]  speed_o,
  output logic        speed_valid_o,
  input  logic        speed_ready_i,
  output logic        stale_o,
  output logic [15:0] byte_cnt_o,
  output logic [7:0]  sentence_cnt_o
);

  localparam logic [TIMER_W-1:0] TIMEOUT_VAL = TIMER_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, POP, LOAD, OFFER} state_t;

  state_t             state_q, state_d;
  logic               handshake;
  logic               accept;
  logic [TIMER_W-1:0] timer_q;

  assign handshake         = dec_valid_o & dec_ready_i;
  assign dec_speed_ready_o = ~speed_valid_o | speed_ready_i;
  assign accept            = dec_speed_valid_i & dec_speed_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable_i && !fifo_empty_i) state_d = POP;
      POP:     state_d = LOAD;
      LOAD:    state_d = OFFER;
      OFFER:   if (dec_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so that they line up with the state they belong to.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_rd_o      <= 1'b0;
      dec_valid_o    <= 1'b0;
      dec_data_o     <= '0;
      byte_cnt_o     <= '0;
      sentence_cnt_o <= '0;
    end else begin
      fifo_rd_o   <= (state_d == POP);
      dec_valid_o <= (state_d == OFFER);
      if (state_q == LOAD) dec_data_o <= fifo_data_i;
      if (handshake) begin
        byte_cnt_o <= byte_cnt_o + 16'd1;
        if (dec_data_o == 8'h24) sentence_cnt_o <= sentence_cnt_o + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      speed_o       <= '0;
      speed_valid_o <= 1'b0;
    end else if (accept) begin
      speed_o       <= dec_speed_i;
      speed_valid_o <= 1'b1;
    end else if (speed_ready_i) begin
      speed_valid_o <= 1'b0;
    end
  end

  // stale_o is only ever set here on the saturating step; an accept is the only thing that clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q <= '0;
      stale_o <= 1'b1;
    end else if (accept) begin
      timer_q <= '0;
      stale_o <= 1'b0;
    end else if (timer_q != TIMEOUT_VAL) begin
      timer_q <= timer_q + 1'b1;
      if (timer_q == TIMEOUT_VAL - 1'b1) stale_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gps_stream_ctrl.sv
// Directed bench for gps_stream_ctrl: a FIFO model feeds the DUT, and every expected value is computed by hand.
module tb_gps_stream_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        enable_i = 1'b0;
  logic [7:0]  fifo_data_i = '0;
  logic        fifo_empty_i;
  logic        fifo_rd_o;
  logic [7:0]  dec_data_o;
  logic        dec_valid_o;
  logic        dec_ready_i = 1'b0;
  logic [7:0]  dec_speed_i = '0;
  logic        dec_speed_valid_i = 1'b0;
  logic        dec_speed_ready_o;
  logic [7:0]  speed_o;
  logic        speed_valid_o;
  logic        speed_ready_i = 1'b0;
  logic        stale_o;
  logic [15:0] byte_cnt_o;
  logic [7:0]  sentence_cnt_o;

  gps_stream_ctrl #(.TIMEOUT_CYCLES(100), .TIMER_W(24)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i),
    .fifo_data_i(fifo_data_i), .fifo_empty_i(fifo_empty_i), .fifo_rd_o(fifo_rd_o),
    .dec_data_o(dec_data_o), .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
    .dec_speed_i(dec_speed_i), .dec_speed_valid_i(dec_speed_valid_i),
    .dec_speed_ready_o(dec_speed_ready_o), .speed_o(speed_o), .speed_valid_o(speed_valid_o),
    .speed_ready_i(speed_ready_i), .stale_o(stale_o), .byte_cnt_o(byte_cnt_o),
    .sentence_cnt_o(sentence_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] got_q[$];
  int unsigned pop_cnt   = 0;
  int unsigned width_err = 0;
  int unsigned empty_pop = 0;
  logic        rd_prev   = 1'b0;

  assign fifo_empty_i = (fifo_q.size() == 0);

  // FIFO model: read data appears the cycle after the pop strobe.
  always @(posedge clk_i) begin
    if (fifo_rd_o) begin
      pop_cnt <= pop_cnt + 1;
      if (rd_prev) width_err <= width_err + 1;
      if (fifo_q.size() == 0) empty_pop <= empty_pop + 1;
      else fifo_data_i <= fifo_q.pop_front();
    end
    rd_prev <= fifo_rd_o;
    if (rst_ni && dec_valid_o && dec_ready_i) got_q.push_back(dec_data_o);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int unsigned budget);
    bit seen = 1'b0;
    for (int unsigned i = 0; i < budget && !seen; i++) begin
      @(negedge clk_i);
      if (dec_valid_o) seen = 1'b1;
    end
    if (!seen) check("wait_dec_valid", 32'd0, 32'd1);
  endtask

  task automatic wait_rd(input int unsigned budget);
    bit seen = 1'b0;
    for (int unsigned i = 0; i < budget && !seen; i++) begin
      @(negedge clk_i);
      if (fifo_rd_o) seen = 1'b1;
    end
    if (!seen) check("wait_fifo_rd", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_fifo_rd"},     32'(fifo_rd_o),      32'd0);
    check({pfx, "_dec_valid"},   32'(dec_valid_o),    32'd0);
    check({pfx, "_dec_data"},    32'(dec_data_o),     32'd0);
    check({pfx, "_speed_valid"}, 32'(speed_valid_o),  32'd0);
    check({pfx, "_speed"},       32'(speed_o),        32'd0);
    check({pfx, "_byte_cnt"},    32'(byte_cnt_o),     32'd0);
    check({pfx, "_sent_cnt"},    32'(sentence_cnt_o), 32'd0);
    check({pfx, "_stale"},       32'(stale_o),        32'd1);
  endtask

  int unsigned p0;
  logic [7:0]  vtg [6] = '{8'h24, 8'h47, 8'h50, 8'h56, 8'h54, 8'h47};

  initial begin
    repeat (3) @(negedge clk_i);
    check_reset_outputs("rst");
    check("rst_dec_speed_ready", 32'(dec_speed_ready_o), 32'd1);
    rst_ni = 1'b1;

    // "$GPVTG" streamed with the decoder always ready
    for (int i = 0; i < 6; i++) fifo_q.push_back(vtg[i]);
    @(negedge clk_i);
    enable_i = 1'b1; dec_ready_i = 1'b1;
    repeat (40) @(negedge clk_i);
    check("vtg_pops", pop_cnt, 32'd6);
    check("vtg_rd_width", width_err, 32'd0);
    check("vtg_got_count", got_q.size(), 32'd6);
    for (int i = 0; i < 6 && i < got_q.size(); i++) check($sformatf("vtg_byte%0d", i), 32'(got_q[i]), 32'(vtg[i]));
    check("vtg_byte_cnt", 32'(byte_cnt_o), 32'd6);
    check("vtg_sent_cnt", 32'(sentence_cnt_o), 32'd1);

    // Decoder stall during OFFER
    dec_ready_i = 1'b0;
    fifo_q.push_back(8'h2C); fifo_q.push_back(8'h31);
    wait_valid(20);
    p0 = pop_cnt;
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", 32'(dec_valid_o), 32'd1);
      check("stall_data", 32'(dec_data_o), 32'h2C);
      @(negedge clk_i);
    end
    check("stall_no_pop", pop_cnt, p0);
    check("stall_byte_cnt", 32'(byte_cnt_o), 32'd6);
    dec_ready_i = 1'b1;
    repeat (20) @(negedge clk_i);
    check("stall_byte_cnt_after", 32'(byte_cnt_o), 32'd8);
    check("stall_got_count", got_q.size(), 32'd8);
    if (got_q.size() >= 8) begin
      check("stall_byte6", 32'(got_q[6]), 32'h2C);
      check("stall_byte7", 32'(got_q[7]), 32'h31);
    end

    // enable_i dropped in the LOAD cycle
    fifo_q.push_back(8'h41); fifo_q.push_back(8'h42);
    wait_rd(20);
    @(posedge clk_i); #1;
    enable_i = 1'b0;
    p0 = pop_cnt;
    repeat (20) @(negedge clk_i);
    check("en_no_new_pop", pop_cnt, p0);
    check("en_byte_cnt", 32'(byte_cnt_o), 32'd9);
    check("en_fifo_left", fifo_q.size(), 32'd1);
    if (got_q.size() == 9) check("en_last_byte", 32'(got_q[8]), 32'h41);
    else check("en_got_count", got_q.size(), 32'd9);
    enable_i = 1'b1;
    repeat (12) @(negedge clk_i);
    check("en_resume_byte_cnt", 32'(byte_cnt_o), 32'd10);
    check("en_sent_cnt", 32'(sentence_cnt_o), 32'd1);
    check("fifo_empty_pops", empty_pop, 32'd0);

    // Result holding register with a stalled consumer
    speed_ready_i = 1'b0;
    dec_speed_i = 8'd42; dec_speed_valid_i = 1'b1;
    @(negedge clk_i);
    dec_speed_i = 8'd57;
    @(negedge clk_i);
    check("hold_speed", 32'(speed_o), 32'd42);
    check("hold_valid", 32'(speed_valid_o), 32'd1);
    check("hold_ready_low", 32'(dec_speed_ready_o), 32'd0);
    check("hold_not_stale", 32'(stale_o), 32'd0);
    repeat (3) @(negedge clk_i);
    check("hold_speed_later", 32'(speed_o), 32'd42);
    speed_ready_i = 1'b1;
    #1 check("swap_ready_comb", 32'(dec_speed_ready_o), 32'd1);
    @(posedge clk_i); #1;
    speed_ready_i = 1'b0; dec_speed_valid_i = 1'b0;
    check("swap_speed", 32'(speed_o), 32'd57);
    check("swap_valid", 32'(speed_valid_o), 32'd1);
    @(negedge clk_i);
    speed_ready_i = 1'b1;
    @(negedge clk_i);
    speed_ready_i = 1'b0;
    check("consume_valid", 32'(speed_valid_o), 32'd0);
    check("consume_speed_held", 32'(speed_o), 32'd57);

    // Staleness timeout after an accept of 30
    dec_speed_i = 8'd30; dec_speed_valid_i = 1'b1;
    @(posedge clk_i); #1;
    dec_speed_valid_i = 1'b0;
    check("to_accept_stale", 32'(stale_o), 32'd0);
    repeat (99) @(posedge clk_i);
    #1 check("to_before_timeout", 32'(stale_o), 32'd0);
    @(posedge clk_i);
    #1 check("to_at_timeout", 32'(stale_o), 32'd1);
    check("to_speed_held", 32'(speed_o), 32'd30);
    repeat (5) @(posedge clk_i);
    #1 check("to_stays_stale", 32'(stale_o), 32'd1);
    speed_ready_i = 1'b1; dec_speed_i = 8'd31; dec_speed_valid_i = 1'b1;
    @(posedge clk_i); #1;
    dec_speed_valid_i = 1'b0; speed_ready_i = 1'b0;
    check("to_cleared", 32'(stale_o), 32'd0);
    check("to_new_speed", 32'(speed_o), 32'd31);

    // Asynchronous reset in the middle of OFFER
    dec_ready_i = 1'b0;
    fifo_q.push_back(8'h24);
    wait_valid(20);
    #2 rst_ni = 1'b0;
    #1 check_reset_outputs("arst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    p0 = pop_cnt;
    repeat (6) @(negedge clk_i);
    check("arst_no_pop", pop_cnt, p0);
    check("arst_no_valid", 32'(dec_valid_o), 32'd0);
    dec_ready_i = 1'b1;
    fifo_q.push_back(8'h47);
    repeat (10) @(negedge clk_i);
    check("arst_resume_pop", pop_cnt, p0 + 1);
    check("arst_resume_byte_cnt", 32'(byte_cnt_o), 32'd1);
    check("arst_resume_sent_cnt", 32'(sentence_cnt_o), 32'd0);
    check("arst_resume_data", 32'(dec_data_o), 32'h47);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
